// File: rtl/rsa_exp_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// rsa_exp_sequencer_pkg
// Shared definitions for the ModExp control sequencer: the FSM state
// encoding, the ModExp "complete" state code and default widths.
// -----------------------------------------------------------------------------
package rsa_exp_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CALC_R  = 4'd1,
    S_CALC_T  = 4'd2,
    S_CALC_N0 = 4'd3,
    S_SEND    = 4'd4,
    S_WAIT    = 4'd5,
    S_READ    = 4'd6,
    S_DONE    = 4'd7,
    S_ERROR   = 4'd8
  } seq_state_t;

  localparam int         DEF_KEY_WIDTH  = 4096;
  localparam int         DEF_DATA_WIDTH = 64;
  localparam int         DEF_TIMEOUT    = 16777216;
  localparam logic [4:0] EXP_COMPLETE   = 5'd9;

  // States in which the sequencer waits on an external block and the
  // watchdog is armed.
  function automatic logic is_wait_state(input seq_state_t s);
    return (s == S_CALC_R) || (s == S_CALC_T) || (s == S_CALC_N0) || (s == S_WAIT);
  endfunction

endpackage

// File: rtl/rsa_exp_sequencer_limb_mux.sv
// -----------------------------------------------------------------------------
// rsa_exp_sequencer_limb_mux
// Selects limb 'sel' of the five full-width operands and registers it onto
// the ModExp limb buses. Buses read zero whenever 'en' is low.
// Ports:
//   clk, reset (sync, active-low)
//   en        : drive the selected limbs this cycle
//   sel       : limb index
//   m/e/n/r/t_word : full-width operands
//   m/e/n/r/t_buf  : registered limb buses
// -----------------------------------------------------------------------------
module rsa_exp_sequencer_limb_mux
  import rsa_exp_sequencer_pkg::*;
#(
  parameter int KEY_WIDTH  = DEF_KEY_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IDX_W      = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [IDX_W-1:0]      sel,
  input  logic [KEY_WIDTH-1:0]  m_word,
  input  logic [KEY_WIDTH-1:0]  e_word,
  input  logic [KEY_WIDTH-1:0]  n_word,
  input  logic [KEY_WIDTH-1:0]  r_word,
  input  logic [KEY_WIDTH-1:0]  t_word,
  output logic [DATA_WIDTH-1:0] m_buf,
  output logic [DATA_WIDTH-1:0] e_buf,
  output logic [DATA_WIDTH-1:0] n_buf,
  output logic [DATA_WIDTH-1:0] r_buf,
  output logic [DATA_WIDTH-1:0] t_buf
);

  localparam int NUM_LIMBS = KEY_WIDTH / DATA_WIDTH;

  logic [NUM_LIMBS-1:0][DATA_WIDTH-1:0] m_limbs, e_limbs, n_limbs, r_limbs, t_limbs;

  assign m_limbs = m_word;
  assign e_limbs = e_word;
  assign n_limbs = n_word;
  assign r_limbs = r_word;
  assign t_limbs = t_word;

  // Register the selected limb of every operand.
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_buf <= '0;
      e_buf <= '0;
      n_buf <= '0;
      r_buf <= '0;
      t_buf <= '0;
    end else if (en) begin
      m_buf <= m_limbs[sel];
      e_buf <= e_limbs[sel];
      n_buf <= n_limbs[sel];
      r_buf <= r_limbs[sel];
      t_buf <= t_limbs[sel];
    end else begin
      m_buf <= '0;
      e_buf <= '0;
      n_buf <= '0;
      r_buf <= '0;
      t_buf <= '0;
    end
  end

endmodule

// File: rtl/rsa_exp_sequencer.sv
// -----------------------------------------------------------------------------
// rsa_exp_sequencer
// Control sequencer for the ModExp core: obtains r and t from rtMod and
// nprime0 from modInv (skipped when the modulus matches the cached one),
// streams operands to ModExp one limb per cycle, then collects the result
// limbs into a full-width result. A watchdog aborts any wait that exceeds
// TIMEOUT cycles and raises a sticky error flag.
// Ports:
//   clk, reset (sync, active-low)
//   start/busy/done/error       : host handshake
//   message/exponent/modulus    : operands (held stable while busy)
//   result                      : m^e mod n, updated together with done
//   rt_go/rt_mode/rt_res/rt_done: rtMod request (mode 0 = r, 1 = t)
//   inv_go/inv_res/inv_valid    : modInv request
//   m/e/n/r/t_buf, nprime0      : operand limb buses to ModExp
//   startInput/startCompute/getResult, exp_state, res_out : ModExp control
// -----------------------------------------------------------------------------
module rsa_exp_sequencer
  import rsa_exp_sequencer_pkg::*;
#(
  parameter int KEY_WIDTH  = DEF_KEY_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [KEY_WIDTH-1:0]  message,
  input  logic [KEY_WIDTH-1:0]  exponent,
  input  logic [KEY_WIDTH-1:0]  modulus,
  output logic [KEY_WIDTH-1:0]  result,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  rt_go,
  output logic                  rt_mode,
  input  logic [KEY_WIDTH-1:0]  rt_res,
  input  logic                  rt_done,
  output logic                  inv_go,
  input  logic [63:0]           inv_res,
  input  logic                  inv_valid,
  output logic [DATA_WIDTH-1:0] m_buf,
  output logic [DATA_WIDTH-1:0] e_buf,
  output logic [DATA_WIDTH-1:0] n_buf,
  output logic [DATA_WIDTH-1:0] r_buf,
  output logic [DATA_WIDTH-1:0] t_buf,
  output logic [63:0]           nprime0,
  output logic                  startInput,
  output logic                  startCompute,
  output logic                  getResult,
  input  logic [4:0]            exp_state,
  input  logic [DATA_WIDTH-1:0] res_out
);

  localparam int NUM_LIMBS = KEY_WIDTH / DATA_WIDTH;
  localparam int CNT_W     = $clog2(NUM_LIMBS) + 1;
  localparam int IDX_W     = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam int WD_W      = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] LAST_LIMB = CNT_W'(NUM_LIMBS - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT - 1);

  seq_state_t state_r, next_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [WD_W-1:0]  wd_r;
  logic             timeout_s, accept_s, last_s;
  logic             accept_r, hit_r, cache_valid_r;
  logic [KEY_WIDTH-1:0] n_cache_r, r_reg_r, t_reg_r;
  logic [NUM_LIMBS-1:0][DATA_WIDTH-1:0] acc_r, acc_s;

  // wd_r counts cycles spent in the current wait state; it reaches the limit
  // on the TIMEOUT-th cycle, so the error lands exactly TIMEOUT cycles after entry.
  assign timeout_s = is_wait_state(state_r) && (wd_r == WD_LIMIT);
  assign accept_s  = (state_r == S_IDLE) && !accept_r && start;
  assign last_s    = (cnt_r == LAST_LIMB);

  // Next-state, limb counter and result-accumulator update.
  always_comb begin
    next_s = state_r;
    cnt_s  = '0;
    acc_s  = acc_r;
    case (state_r)
      S_IDLE: begin
        // accept_r marks the extra cycle in which the registered cache compare settles
        if (accept_r) begin
          if (hit_r) next_s = S_SEND;
          else       next_s = S_CALC_R;
        end else begin
          next_s = S_IDLE;
        end
      end
      S_CALC_R: begin
        if (rt_done)        next_s = S_CALC_T;
        else if (timeout_s) next_s = S_ERROR;
        else                next_s = S_CALC_R;
      end
      S_CALC_T: begin
        if (rt_done)        next_s = S_CALC_N0;
        else if (timeout_s) next_s = S_ERROR;
        else                next_s = S_CALC_T;
      end
      S_CALC_N0: begin
        if (inv_valid)      next_s = S_SEND;
        else if (timeout_s) next_s = S_ERROR;
        else                next_s = S_CALC_N0;
      end
      S_SEND: begin
        if (last_s) begin
          next_s = S_WAIT;
        end else begin
          next_s = S_SEND;
          cnt_s  = cnt_r + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (exp_state == EXP_COMPLETE) next_s = S_READ;
        else if (timeout_s)            next_s = S_ERROR;
        else                           next_s = S_WAIT;
      end
      S_READ: begin
        acc_s[cnt_r[IDX_W-1:0]] = res_out;
        if (last_s) begin
          next_s = S_DONE;
        end else begin
          next_s = S_READ;
          cnt_s  = cnt_r + CNT_W'(1);
        end
      end
      S_DONE:  next_s = S_IDLE;
      S_ERROR: next_s = S_IDLE;
      default: next_s = S_IDLE;
    endcase
  end

  // State register, limb counter, watchdog and result accumulator.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      wd_r    <= '0;
      acc_r   <= '0;
    end else begin
      state_r <= next_s;
      cnt_r   <= cnt_s;
      acc_r   <= acc_s;
      if ((next_s != state_r) || !is_wait_state(next_s)) wd_r <= '0;
      else                                               wd_r <= wd_r + WD_W'(1);
    end
  end

  // Start acceptance, modulus cache and precomputed constants.
  always_ff @(posedge clk) begin
    if (!reset) begin
      accept_r      <= 1'b0;
      hit_r         <= 1'b0;
      n_cache_r     <= '0;
      cache_valid_r <= 1'b0;
      r_reg_r       <= '0;
      t_reg_r       <= '0;
      nprime0       <= 64'd0;
    end else begin
      accept_r <= accept_s;
      if (accept_s) begin
        hit_r     <= cache_valid_r && (modulus == n_cache_r);
        n_cache_r <= modulus;
      end
      // A miss invalidates the cache until the new constants are complete
      if ((next_s == S_ERROR) || (accept_r && !hit_r)) cache_valid_r <= 1'b0;
      else if ((state_r == S_CALC_N0) && (next_s == S_SEND)) cache_valid_r <= 1'b1;
      if ((state_r == S_CALC_R) && rt_done) r_reg_r <= rt_res;
      if ((state_r == S_CALC_T) && rt_done) t_reg_r <= rt_res;
      if ((state_r == S_CALC_N0) && inv_valid) nprime0 <= inv_res;
    end
  end

  // Registered host and block-control outputs, derived from the transition.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      rt_go        <= 1'b0;
      rt_mode      <= 1'b0;
      inv_go       <= 1'b0;
      startInput   <= 1'b0;
      startCompute <= 1'b0;
      getResult    <= 1'b0;
      result       <= '0;
    end else begin
      busy         <= accept_s || ((next_s != S_IDLE) && (next_s != S_ERROR));
      done         <= (next_s == S_DONE);
      rt_go        <= ((next_s == S_CALC_R) && (state_r != S_CALC_R)) ||
                      ((next_s == S_CALC_T) && (state_r != S_CALC_T));
      rt_mode      <= (next_s == S_CALC_T);
      inv_go       <= (next_s == S_CALC_N0) && (state_r != S_CALC_N0);
      startInput   <= (next_s == S_SEND);
      getResult    <= (state_r == S_SEND) && (next_s == S_WAIT);
      startCompute <= ((state_r == S_SEND) && (next_s == S_WAIT)) ||
                      ((state_r == S_WAIT) && (next_s == S_READ));
      if (next_s == S_ERROR) error <= 1'b1;
      else if (accept_s)     error <= 1'b0;
      // result changes only together with the done pulse
      if ((state_r == S_READ) && (next_s == S_DONE)) result <= acc_s;
    end
  end

  // The limb index is the next counter value so the registered bus lines up
  // with startInput in the same cycle.
  rsa_exp_sequencer_limb_mux #(
    .KEY_WIDTH  (KEY_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_limb_mux (
    .clk    (clk),
    .reset  (reset),
    .en     (next_s == S_SEND),
    .sel    (cnt_s[IDX_W-1:0]),
    .m_word (message),
    .e_word (exponent),
    .n_word (n_cache_r),
    .r_word (r_reg_r),
    .t_word (t_reg_r),
    .m_buf  (m_buf),
    .e_buf  (e_buf),
    .n_buf  (n_buf),
    .r_buf  (r_buf),
    .t_buf  (t_buf)
  );

endmodule
